// File: rtl/lc_target_pkg.sv
// Shared types for the life-cycle transition target sequencer.
// Decoded/encoded state types, FSM states and the redundant encoder.
package lc_target_pkg;

    localparam int unsigned DecWidth    = 6;
    localparam int unsigned NumLcStates = 21;

    typedef logic [DecWidth-1:0]   dec_lc_state_t;
    typedef logic [2*DecWidth-1:0] enc_lc_state_t;

    typedef enum logic [1:0] {
        StIdle,
        StEmit,
        StDone
    } lc_seq_state_e;

    // The complement half lets the consumer detect single-bit upsets.
    function automatic enc_lc_state_t lc_encode(input dec_lc_state_t dec);
        return {dec, ~dec};
    endfunction

endpackage

// File: rtl/lc_state_enc.sv
// Combinational legality check and redundant encoding of one state.
module lc_state_enc
    import lc_target_pkg::*;
#(
    parameter int unsigned LegalLimit = NumLcStates
) (
    input  dec_lc_state_t i_dec,
    output enc_lc_state_t o_enc,
    output logic          o_legal
);

    localparam dec_lc_state_t Limit = dec_lc_state_t'(LegalLimit);

    assign o_enc   = lc_encode(i_dec);
    assign o_legal = (i_dec < Limit);

endmodule

// File: rtl/lc_target_seq.sv
// Walks a latched array of decoded life-cycle targets and emits the
// legal ones over valid/ready together with their redundant encoding.
module lc_target_seq #(
    parameter int unsigned NumTargets  = 5,
    parameter int unsigned DecWidth    = 6,
    parameter int unsigned NumLcStates = 21
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           load_i,
    input  logic [NumTargets*DecWidth-1:0] targets_i,
    input  logic [2:0]                     count_i,
    output logic                           tgt_valid_o,
    input  logic                           tgt_ready_i,
    output logic [DecWidth-1:0]            tgt_dec_o,
    output logic [2*DecWidth-1:0]          tgt_enc_o,
    output logic [2:0]                     tgt_idx_o,
    output logic                           tgt_last_o,
    output logic                           busy_o,
    output logic                           done_o,
    output logic                           err_o
);

    typedef lc_target_pkg::lc_seq_state_e state_e;

    localparam logic [2:0] MaxCnt = 3'(NumTargets);

    state_e r_state;
    state_e w_next;

    logic [DecWidth-1:0] r_elem [NumTargets];
    logic [2:0]          r_idx;
    logic [2:0]          r_cnt;
    logic                r_err;

    logic [DecWidth-1:0]   w_sel;
    logic [2*DecWidth-1:0] w_enc;
    logic                  w_legal;
    logic                  w_load;
    logic                  w_last;
    logic                  w_valid;
    logic                  w_busy;
    logic                  w_done;
    logic                  w_step;
    logic [2:0]            w_cnt_in;

    assign w_cnt_in = (count_i > MaxCnt) ? MaxCnt : count_i;
    assign w_load   = load_i && (r_state == lc_target_pkg::StIdle);
    assign w_sel    = r_elem[r_idx];
    assign w_last   = (r_idx == r_cnt - 3'd1);

    lc_state_enc #(
        .LegalLimit(NumLcStates)
    ) u_enc (
        .i_dec  (w_sel),
        .o_enc  (w_enc),
        .o_legal(w_legal)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= lc_target_pkg::StIdle;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_valid = 1'b0;
        w_busy  = 1'b0;
        w_done  = 1'b0;
        w_step  = 1'b0;
        unique case (r_state)
            lc_target_pkg::StIdle: begin
                if (w_load) begin
                    w_next = (w_cnt_in != 3'd0) ? lc_target_pkg::StEmit
                                                : lc_target_pkg::StDone;
                end
            end
            lc_target_pkg::StEmit: begin
                w_busy  = 1'b1;
                w_valid = w_legal;
                // Illegal elements are dropped after a single cycle.
                w_step  = !w_legal || tgt_ready_i;
                if (w_step && w_last) begin
                    w_next = lc_target_pkg::StDone;
                end
            end
            lc_target_pkg::StDone: begin
                w_busy = 1'b1;
                w_done = 1'b1;
                w_next = lc_target_pkg::StIdle;
            end
            default: begin
                w_next = lc_target_pkg::StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_idx <= '0;
            r_cnt <= '0;
            r_err <= 1'b0;
            for (int i = 0; i < NumTargets; i++) begin
                r_elem[i] <= '0;
            end
        end else if (w_load) begin
            for (int i = 0; i < NumTargets; i++) begin
                r_elem[i] <= targets_i[i*DecWidth +: DecWidth];
            end
            r_cnt <= w_cnt_in;
            r_idx <= '0;
            r_err <= (count_i > MaxCnt);
        end else if (w_step) begin
            r_idx <= r_idx + 3'd1;
            if (!w_legal) begin
                r_err <= 1'b1;
            end
        end
    end

    assign tgt_valid_o = w_valid;
    assign tgt_dec_o   = w_valid ? w_sel : '0;
    assign tgt_enc_o   = w_valid ? w_enc : '0;
    assign tgt_idx_o   = w_valid ? r_idx : '0;
    assign tgt_last_o  = w_valid && w_last;
    assign busy_o      = w_busy;
    assign done_o      = w_done;
    assign err_o       = r_err;

endmodule

// File: tb/tb_lc_target_seq.sv
// Bench for lc_target_seq: slot-queue reference model checked every cycle
// plus literal expectations per directed scenario.
module tb_lc_target_seq;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        load_i = 1'b0;
    logic [29:0] targets_i = '0;
    logic [2:0]  count_i = '0;
    logic        tgt_valid_o;
    logic        tgt_ready_i = 1'b1;
    logic [5:0]  tgt_dec_o;
    logic [11:0] tgt_enc_o;
    logic [2:0]  tgt_idx_o;
    logic        tgt_last_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    lc_target_seq dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (load_i),
        .targets_i  (targets_i),
        .count_i    (count_i),
        .tgt_valid_o(tgt_valid_o),
        .tgt_ready_i(tgt_ready_i),
        .tgt_dec_o  (tgt_dec_o),
        .tgt_enc_o  (tgt_enc_o),
        .tgt_idx_o  (tgt_idx_o),
        .tgt_last_o (tgt_last_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    // One slot per cycle-consuming step: an element visit or the done pulse.
    typedef struct {
        bit         is_done;
        bit         legal;
        logic [2:0] idx;
        logic [5:0] dec;
        bit         last;
    } slot_t;

    slot_t q[$];
    bit    m_err = 1'b0;

    int lg_idx[$];
    int lg_dec[$];
    int lg_enc[$];
    int lg_last[$];
    int n_done = 0;
    int n_idx2 = 0;

    always @(negedge clk_i) begin
        bit         ev, eb, ed, el;
        logic [5:0] edec;
        logic [2:0] eidx;
        int         cnt;
        slot_t      s;
        ev = 0; eb = 0; ed = 0; el = 0; edec = '0; eidx = '0;
        if (q.size() != 0) begin
            eb = 1;
            if (q[0].is_done) begin
                ed = 1;
            end else if (q[0].legal) begin
                ev   = 1;
                edec = q[0].dec;
                eidx = q[0].idx;
                el   = q[0].last;
            end
        end
        chk("valid", tgt_valid_o, ev);
        chk("dec", tgt_dec_o, edec);
        chk("enc", tgt_enc_o, {edec, ~edec} & {12{ev}});
        chk("idx", tgt_idx_o, eidx);
        chk("last", tgt_last_o, el);
        chk("busy", busy_o, eb);
        chk("done", done_o, ed);
        chk("err", err_o, m_err);

        if (tgt_valid_o && tgt_ready_i) begin
            lg_idx.push_back(int'(tgt_idx_o));
            lg_dec.push_back(int'(tgt_dec_o));
            lg_enc.push_back(int'(tgt_enc_o));
            lg_last.push_back(int'(tgt_last_o));
        end
        if (tgt_valid_o && tgt_idx_o == 3'd2) n_idx2++;
        if (done_o) n_done++;

        if (!rst_ni) begin
            q.delete();
            m_err = 0;
        end else if (q.size() != 0) begin
            if (q[0].is_done) begin
                void'(q.pop_front());
            end else if (!q[0].legal) begin
                m_err = 1;
                void'(q.pop_front());
            end else if (tgt_ready_i) begin
                void'(q.pop_front());
            end
        end else if (load_i) begin
            cnt   = (count_i > 3'd5) ? 5 : int'(count_i);
            m_err = (count_i > 3'd5);
            for (int p = 0; p < cnt; p++) begin
                s.is_done = 0;
                s.dec     = targets_i[p*6 +: 6];
                s.legal   = (s.dec < 6'd21);
                s.idx     = 3'(p);
                s.last    = (p == cnt - 1);
                q.push_back(s);
            end
            s = '{is_done: 1, legal: 0, idx: '0, dec: '0, last: 0};
            q.push_back(s);
        end
    end

    function automatic logic [29:0] pk(input int a, input int b, input int c,
                                       input int d, input int e);
        return {e[5:0], d[5:0], c[5:0], b[5:0], a[5:0]};
    endfunction

    task automatic clr_log();
        lg_idx.delete();
        lg_dec.delete();
        lg_enc.delete();
        lg_last.delete();
        n_idx2 = 0;
    endtask

    task automatic do_load(input logic [29:0] t, input logic [2:0] c);
        @(posedge clk_i); #1;
        targets_i = t;
        count_i   = c;
        load_i    = 1'b1;
        @(posedge clk_i); #1;
        load_i    = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        for (int k = 0; k < 80 && n_done <= d0; k++) begin
            @(posedge clk_i); #1;
        end
        chk("done_timeout", n_done > d0, 1);
        @(posedge clk_i); #1;
    endtask

    initial begin
        int d0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_valid", tgt_valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_err", err_o, 0);
        rst_ni = 1'b1;

        // Full sequence
        clr_log();
        d0 = n_done;
        do_load(pk(0, 1, 2, 3, 4), 3'd5);
        wait_done(d0);
        chk("full_nbeats", lg_idx.size(), 5);
        for (int i = 0; i < lg_idx.size(); i++) begin
            chk("full_idx", lg_idx[i], i);
            chk("full_dec", lg_dec[i], i);
            chk("full_last", lg_last[i], (i == 4) ? 1 : 0);
        end
        if (lg_enc.size() > 3) chk("full_enc3", lg_enc[3], 12'h0FC);
        else chk("full_enc3_missing", lg_enc.size(), 5);
        chk("full_err", err_o, 0);

        // Backpressure on idx 2
        clr_log();
        d0 = n_done;
        do_load(pk(0, 1, 2, 3, 4), 3'd5);
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        tgt_ready_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        tgt_ready_i = 1'b1;
        wait_done(d0);
        chk("bp_nbeats", lg_idx.size(), 5);
        for (int i = 0; i < lg_idx.size(); i++) begin
            chk("bp_idx", lg_idx[i], i);
        end
        chk("bp_idx2_cycles", n_idx2, 4);

        // Illegal element skipped
        clr_log();
        d0 = n_done;
        do_load(pk(5, 63, 7, 0, 0), 3'd3);
        wait_done(d0);
        chk("ill_nbeats", lg_idx.size(), 2);
        if (lg_idx.size() == 2) begin
            chk("ill_idx0", lg_idx[0], 0);
            chk("ill_dec0", lg_dec[0], 5);
            chk("ill_last0", lg_last[0], 0);
            chk("ill_idx1", lg_idx[1], 2);
            chk("ill_dec1", lg_dec[1], 7);
            chk("ill_last1", lg_last[1], 1);
        end
        repeat (3) @(posedge clk_i);
        #1;
        chk("ill_err_sticky", err_o, 1);

        // count = 0
        clr_log();
        d0 = n_done;
        do_load(pk(1, 2, 3, 4, 5), 3'd0);
        chk("c0_done_t1", done_o, 1);
        chk("c0_err_cleared", err_o, 0);
        wait_done(d0);
        chk("c0_nbeats", lg_idx.size(), 0);

        // count = 7 clamps to 5
        clr_log();
        d0 = n_done;
        do_load(pk(1, 2, 3, 4, 5), 3'd7);
        wait_done(d0);
        chk("c7_nbeats", lg_idx.size(), 5);
        chk("c7_err", err_o, 1);

        // Load while busy is dropped
        clr_log();
        d0 = n_done;
        do_load(pk(10, 11, 12, 13, 14), 3'd5);
        targets_i = pk(1, 1, 1, 1, 1);
        count_i   = 3'd2;
        load_i    = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        load_i = 1'b0;
        wait_done(d0);
        chk("lwb_nbeats", lg_idx.size(), 5);
        for (int i = 0; i < lg_dec.size(); i++) begin
            chk("lwb_dec", lg_dec[i], 10 + i);
        end
        chk("lwb_err", err_o, 0);

        // Reset during Emit at idx 2
        clr_log();
        do_load(pk(0, 1, 2, 3, 4), 3'd5);
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        chk("mid_idx_pre", tgt_idx_o, 2);
        rst_ni = 1'b0;
        d0 = n_done;
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        chk("mid_valid", tgt_valid_o, 0);
        chk("mid_busy", busy_o, 0);
        chk("mid_done", done_o, 0);
        chk("mid_dec", tgt_dec_o, 0);
        repeat (5) @(posedge clk_i);
        #1;
        chk("mid_no_done", n_done, d0);

        clr_log();
        d0 = n_done;
        do_load(pk(20, 3, 9, 0, 17), 3'd5);
        wait_done(d0);
        chk("post_nbeats", lg_idx.size(), 5);
        if (lg_dec.size() == 5) chk("post_dec0", lg_dec[0], 20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
